// File: rtl/bag_pkg.sv
// bag_pkg: bag FSM states, coordinate width and the y saturation helper
package bag_pkg;
  localparam int CW = 12;
  typedef enum logic {IDLE, FLY} bag_state_t;
  function automatic logic [CW-1:0] sat_coord(input logic [27:0] v);
    return (v > 28'd4095) ? 12'hfff : v[CW-1:0];
  endfunction
endpackage

// File: rtl/bag_launcher_if.sv
// bag_launcher_if: launcher controls and packed per-bag coordinates/events
interface bag_launcher_if import bag_pkg::*; #(parameter int N_BAGS = 4) ();
  localparam int IW = N_BAGS > 1 ? $clog2(N_BAGS) : 1;
  logic enable;
  logic [9:0] random;
  logic catch_valid;
  logic [IW-1:0] catch_idx;
  logic [CW*N_BAGS-1:0] xpos, ypos;
  logic [N_BAGS-1:0] active, caught, missed;
  modport master (output enable, random, catch_valid, catch_idx,
                  input xpos, ypos, active, caught, missed);
  modport slave (input enable, random, catch_valid, catch_idx,
                 output xpos, ypos, active, caught, missed);
endinterface

// File: rtl/bag_traj.sv
// bag_traj: one bag's flight FSM, latched arc scale and parabolic y arithmetic
module bag_traj import bag_pkg::*; #(
  parameter int X_START = 0,
  parameter int X_END = 600,
  parameter int Y_START = 100,
  parameter int Y_END = 600,
  parameter int SHIFT = 10,
  parameter int SCALE_MOD = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_grant,
  input  logic i_catch,
  input  logic [9:0] i_random,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic o_active,
  output logic o_caught,
  output logic o_missed
);
  bag_state_t r_state, w_state;
  logic [CW-1:0] r_x, r_y, w_x, w_y, w_xn, w_ynew;
  logic [3:0] r_scale, w_scale;
  logic r_caught, r_missed, w_caught, w_missed, w_out;
  logic [23:0] w_sq;
  logic [27:0] w_prod;
  // y is derived from the advanced x, saturated rather than wrapped
  assign w_xn = r_x + 12'd1;
  assign w_sq = 24'(w_xn) * 24'(w_xn);
  assign w_prod = (28'(r_scale) + 28'd1) * 28'(w_sq);
  assign w_ynew = sat_coord((w_prod >> SHIFT) + 28'(Y_START));
  assign w_out = (r_x >= CW'(X_END)) || (r_y >= CW'(Y_END));
  always_comb begin
    w_state = r_state;
    w_x = r_x;
    w_y = r_y;
    w_scale = r_scale;
    w_caught = 1'b0;
    w_missed = 1'b0;
    if (r_state == IDLE) begin
      if (i_grant) begin
        w_state = FLY;
        w_scale = 4'(i_random % 10'(SCALE_MOD));
        w_x = CW'(X_START);
        w_y = CW'(Y_START);
      end
    end else if (i_catch || (i_tick && w_out)) begin
      w_state = IDLE;
      w_x = CW'(X_START);
      w_y = CW'(Y_START);
      w_caught = i_catch;
      w_missed = !i_catch;
    end else if (i_tick) begin
      w_x = w_xn;
      w_y = w_ynew;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x <= CW'(X_START);
      r_y <= CW'(Y_START);
      r_scale <= '0;
      r_caught <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x <= w_x;
      r_y <= w_y;
      r_scale <= w_scale;
      r_caught <= w_caught;
      r_missed <= w_missed;
    end
  end
  assign o_x = r_x;
  assign o_y = r_y;
  assign o_active = (r_state == FLY);
  assign o_caught = r_caught;
  assign o_missed = r_missed;
endmodule

// File: rtl/bag_launcher.sv
// bag_launcher: tick divider, staggered launch arbiter and N_BAGS trajectory engines
module bag_launcher import bag_pkg::*; #(
  parameter int N_BAGS = 4,
  parameter int TICK_DIV = 800000,
  parameter int X_START = 0,
  parameter int X_END = 600,
  parameter int Y_START = 100,
  parameter int Y_END = 600,
  parameter int SHIFT = 10,
  parameter int SCALE_MOD = 5,
  parameter int SPAWN_GAP = 150
) (
  input logic clk,
  input logic rst_n,
  bag_launcher_if.slave bus
);
  logic [31:0] r_div, r_gap;
  logic w_tick, w_launch;
  logic [N_BAGS-1:0] w_idle, w_grant, w_catch, w_act, w_caught, w_missed;
  logic [CW-1:0] w_x [N_BAGS];
  logic [CW-1:0] w_y [N_BAGS];
  assign w_tick = bus.enable && (r_div == 32'(TICK_DIV - 1));
  assign w_launch = w_tick && (r_gap == 32'(SPAWN_GAP - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_gap <= 32'(SPAWN_GAP - 1);
    end else begin
      if (bus.enable) r_div <= w_tick ? '0 : r_div + 32'd1;
      if (w_tick) r_gap <= w_launch ? '0 : r_gap + 32'd1;
    end
  end
  // idle is taken from registered state, so a bag retiring this cycle cannot be granted
  assign w_idle = w_launch ? ~w_act : '0;
  assign w_grant = w_idle & (~w_idle + N_BAGS'(1));
  for (genvar g = 0; g < N_BAGS; g++) begin : g_bag
    assign w_catch[g] = bus.catch_valid && (32'(bus.catch_idx) == g);
    bag_traj #(
      .X_START(X_START), .X_END(X_END), .Y_START(Y_START), .Y_END(Y_END),
      .SHIFT(SHIFT), .SCALE_MOD(SCALE_MOD)
    ) u_bag (
      .clk(clk),
      .rst_n(rst_n),
      .i_tick(w_tick),
      .i_grant(w_grant[g]),
      .i_catch(w_catch[g]),
      .i_random(bus.random),
      .o_x(w_x[g]),
      .o_y(w_y[g]),
      .o_active(w_act[g]),
      .o_caught(w_caught[g]),
      .o_missed(w_missed[g])
    );
    assign bus.xpos[CW*g +: CW] = w_x[g];
    assign bus.ypos[CW*g +: CW] = w_y[g];
  end
  assign bus.active = w_act;
  assign bus.caught = w_caught;
  assign bus.missed = w_missed;
endmodule
